// File: rtl/vecsum_reducer.sv
// Streams a signed vector from on-chip memory (1-cycle read latency) and reduces it to one total.
// Build option: define VECSUM_SATURATE_EN to clamp the total on signed overflow instead of wrapping.
module vecsum_reducer #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ack,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [31:0]       len,
  output logic [ADDR_W-1:0] mem_address,
  output logic              cs,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              overflow,
  output logic [3:0]        state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [31:0]       len_reg, len_next;
  logic [31:0]       cnt_reg, cnt_next;
  logic              valid_reg, valid_next;
  logic [DATA_W-1:0] acc_reg, acc_next;
  logic              ovf_reg, ovf_next;

  logic [DATA_W-1:0] sum;
  logic              add_ovf;
  logic [DATA_W-1:0] add_res;

  // Signed overflow: operands share a sign that the wrapped sum does not.
  assign sum     = acc_reg + mem_rdata;
  assign add_ovf = (acc_reg[DATA_W-1] == mem_rdata[DATA_W-1]) &&
                   (sum[DATA_W-1] != acc_reg[DATA_W-1]);

`ifdef VECSUM_SATURATE_EN
  assign add_res = add_ovf ? (acc_reg[DATA_W-1] ? SAT_MIN : SAT_MAX) : sum;
`else
  assign add_res = sum;
`endif

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    len_next   = len_reg;
    cnt_next   = cnt_reg;
    valid_next = 1'b0;
    acc_next   = acc_reg;
    ovf_next   = ovf_reg;

    // Data returned for the previous issue cycle lands here, in STREAM or DRAIN.
    if (valid_reg) begin
      acc_next = add_res;
      ovf_next = ovf_reg | add_ovf;
    end

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          addr_next  = base_addr;
          len_next   = len;
          cnt_next   = 32'd0;
          acc_next   = '0;
          ovf_next   = 1'b0;
          state_next = (len == 32'd0) ? S_DONE : S_STREAM;
        end
      end
      S_STREAM: begin
        valid_next = 1'b1;
        addr_next  = addr_reg + ADDR_W'(4);
        cnt_next   = cnt_reg + 32'd1;
        if (cnt_reg == len_reg - 32'd1) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_next = S_DONE;
      end
      S_DONE: begin
        if (ack) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      addr_reg  <= '0;
      len_reg   <= 32'd0;
      cnt_reg   <= 32'd0;
      valid_reg <= 1'b0;
      acc_reg   <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      len_reg   <= len_next;
      cnt_reg   <= cnt_next;
      valid_reg <= valid_next;
      acc_reg   <= acc_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign mem_address = addr_reg;
  assign cs          = (state_reg == S_STREAM);
  assign mem_write   = 1'b0;
  assign busy        = (state_reg == S_STREAM) || (state_reg == S_DRAIN);
  assign done        = (state_reg == S_DONE);
  assign result      = acc_reg;
  assign overflow    = ovf_reg;
  assign state       = {2'b00, state_reg};

endmodule

// File: tb/tb_vecsum_reducer.sv
// Randomized self-checking bench for vecsum_reducer against an arithmetic reference model.
// Honors VECSUM_SATURATE_EN the same way the design does.
module tb_vecsum_reducer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        ack;
  logic [13:0] base_addr;
  logic [31:0] len;
  logic [13:0] mem_address;
  logic        cs;
  logic        mem_write;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        overflow;
  logic [3:0]  state;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  logic [31:0] mem [0:4095];
  logic [31:0] elems [$];

  always #5 clk = ~clk;

  vecsum_reducer #(.ADDR_W(14), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .ack(ack),
    .base_addr(base_addr), .len(len),
    .mem_address(mem_address), .cs(cs), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .busy(busy), .done(done),
    .result(result), .overflow(overflow), .state(state)
  );

  // Memory with 1-cycle registered read; junk when not selected so stray accumulation shows up.
  always @(posedge clk) begin
    if (cs) mem_rdata <= mem[mem_address[13:2]];
    else    mem_rdata <= $urandom;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: exact integer sum step by step, then wrap or clamp.
  task automatic model(output logic [31:0] res, output logic ovf);
    longint acc = 0;
    longint t;
    ovf = 1'b0;
    foreach (elems[i]) begin
      t = acc + longint'($signed(elems[i]));
      if (t > 64'sd2147483647 || t < -64'sd2147483648) ovf = 1'b1;
`ifdef VECSUM_SATURATE_EN
      if (t > 64'sd2147483647) acc = 64'sd2147483647;
      else if (t < -64'sd2147483648) acc = -64'sd2147483648;
      else acc = t;
`else
      acc = longint'($signed(t[31:0]));
`endif
    end
    res = acc[31:0];
  endtask

  function automatic logic [13:0] elem_addr(input logic [13:0] base, input int i);
    int a;
    a = (int'(base) + 4 * i) & 32'h3FFF;
    return a[13:0];
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One complete run of elems from base; optional stray starts during STREAM and DONE.
  task automatic run_vec(input logic [13:0] base, input bit start_mid, input bit start_done);
    int n;
    logic [31:0] exp_res;
    logic        exp_ovf;
    n = elems.size();
    foreach (elems[i]) mem[elem_addr(base, i) >> 2] = elems[i];
    model(exp_res, exp_ovf);

    start = 1'b1; base_addr = base; len = n;
    next_cycle();
    start = 1'b0; base_addr = 14'($urandom); len = $urandom_range(1, 50);
    if (n == 0) begin
      check_eq("len0_state", state, 4'd3);
      check_eq("len0_cs", cs, 1'b0);
    end else begin
      for (int c = 0; c < n; c++) begin
        check_eq("stream_cs", cs, 1'b1);
        check_eq("stream_addr", mem_address, elem_addr(base, c));
        check_eq("stream_busy", busy, 1'b1);
        check_eq("stream_done", done, 1'b0);
        check_eq("mem_write", mem_write, 1'b0);
        if (start_mid && c == 0) start = 1'b1;
        next_cycle();
        start = 1'b0;
      end
      check_eq("drain_state", state, 4'd2);
      check_eq("drain_cs", cs, 1'b0);
      check_eq("drain_busy", busy, 1'b1);
      next_cycle();
    end
    check_eq("done", done, 1'b1);
    check_eq("done_busy", busy, 1'b0);
    check_eq("result", result, exp_res);
    check_eq("overflow", overflow, exp_ovf);
    if (start_done) begin
      start = 1'b1;
      next_cycle();
      start = 1'b0;
      check_eq("done_hold_state", state, 4'd3);
      check_eq("done_hold_cs", cs, 1'b0);
      check_eq("done_hold_result", result, exp_res);
    end
    ack = 1'b1; start = start_done;
    next_cycle();
    ack = 1'b0; start = 1'b0;
    check_eq("ack_state", state, 4'd0);
    check_eq("ack_done", done, 1'b0);
    check_eq("ack_result", result, exp_res);
    next_cycle();
    check_eq("idle_cs", cs, 1'b0);
    check_eq("idle_state", state, 4'd0);
    $display("run base=%h len=%0d result=%h overflow=%b", base, n, exp_res, exp_ovf);
  endtask

  initial begin
    int n;
    logic [13:0] b;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    reset = 1'b1; start = 1'b0; ack = 1'b0; base_addr = '0; len = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_state", state, 4'd0);
    check_eq("rst_cs", cs, 1'b0);
    check_eq("rst_addr", mem_address, 14'h0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_result", result, 32'h0);
    check_eq("rst_ovf", overflow, 1'b0);
    reset = 1'b0;
    next_cycle();

    elems = '{32'd1, 32'd2, 32'd3, 32'd4};
    run_vec(14'h100, 1'b0, 1'b0);
    elems = '{32'hFFFFFFFB, 32'h00000003};
    run_vec(14'h200, 1'b0, 1'b0);
    elems = '{32'h7FFFFFFF, 32'h00000001, 32'h00000001};
    run_vec(14'h300, 1'b0, 1'b0);
    elems = '{};
    run_vec(14'h040, 1'b0, 1'b1);
    elems = '{32'h80000000, 32'hFFFFFFFF, 32'h00000005};
    run_vec(14'h080, 1'b0, 1'b0);
    elems = '{32'd10, 32'd20, 32'd30};
    run_vec(14'h3FFC, 1'b1, 1'b1);

    // Reset in cycle 3 of a len=8 run aborts it.
    elems = '{};
    for (int i = 0; i < 8; i++) elems.push_back($urandom);
    foreach (elems[i]) mem[elem_addr(14'h500, i) >> 2] = elems[i];
    start = 1'b1; base_addr = 14'h500; len = 32'd8;
    next_cycle();
    start = 1'b0;
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    check_eq("abort_state", state, 4'd0);
    check_eq("abort_cs", cs, 1'b0);
    check_eq("abort_done", done, 1'b0);
    check_eq("abort_result", result, 32'h0);
    check_eq("abort_ovf", overflow, 1'b0);
    next_cycle();
    check_eq("abort_idle_cs", cs, 1'b0);
    $display("run base=500 len=8 aborted by reset");
    elems = '{32'd7, 32'hFFFFFFFF, 32'd100};
    run_vec(14'h600, 1'b0, 1'b0);

    for (int r = 0; r < 14; r++) begin
      n = $urandom_range(1, 20);
      b = 14'($urandom_range(0, 4095) * 4);
      elems = '{};
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) == 1) elems.push_back($urandom);
        else elems.push_back(32'($urandom_range(0, 200)) - 32'd100);
      end
      run_vec(b, r[0], r[1]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
